instruction_memory: RTL and testbench

//  Byte-addressable, read-only instruction memory for the IF stage of the
//  32-bit pipelined RISC-V core. PC from the fetch stage drives address;
//  the 32-bit instruction is returned one clock later for the IF/ID register.

---
 rtl/instruction_memory.sv | 108 ++++++++++
 tb/tb_instruction_memory.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/instruction_memory.sv
// instruction_memory: byte-addressable read-only instruction store for the
// fetch stage. The 32-bit word starting at the byte address is returned
// little-endian, registered, one clock after the address is presented.
// Contents come from a built-in five-instruction program and are never
// modified at run time.
module instruction_memory #(
    parameter int          DEPTH_BYTES = 1024,
    parameter string       INIT_FILE   = "",
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address,
    output logic [31:0] read_instr
);

    // Index width into the byte array; at least one bit so tiny depths still elaborate.
    localparam int IDX_W = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    // Byte lane addresses are formed one bit wider than the PC so that a word
    // near 32'hFFFF_FFFF never wraps back onto low memory.
    localparam logic [32:0] DEPTH_EXT = 33'(DEPTH_BYTES);

    // Read-only byte storage.
    logic [7:0] mem [0:DEPTH_BYTES-1];

    // Assembled word for the current address, before the output register.
    logic [31:0] fetch_word;

    // ------------------------------------------------------------------
    // Parameter sanity: the layout assumes whole words and room for the
    // built-in program (five words = 20 bytes, plus slack).
    // ------------------------------------------------------------------
    generate
        if ((DEPTH_BYTES % 4) != 0 || DEPTH_BYTES < 24) begin : g_bad_depth
            $error("instruction_memory: DEPTH_BYTES must be a multiple of 4 and >= 24");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Memory image: the built-in program as a constant ROM.
    // ------------------------------------------------------------------

    // Built-in program, one instruction per word slot; everything else is 0.
    function automatic logic [31:0] prog_word(input int word_idx);
        logic [31:0] w;
        case (word_idx)
            0:       w = 32'h0050_0093; // addi x1,x0,5
            1:       w = 32'h00A0_0113; // addi x2,x0,10
            2:       w = 32'h0020_81B3; // add  x3,x1,x2
            3:       w = 32'h0030_2023; // sw   x3,0(x0)
            4:       w = 32'h0000_2203; // lw   x4,0(x0)
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Little-endian byte of the built-in program at a given byte index.
    function automatic logic [7:0] default_byte(input int byte_idx);
        logic [31:0] w;
        w = prog_word(byte_idx / 4);
        return w[(byte_idx % 4) * 8 +: 8];
    endfunction

    generate
        for (genvar gi = 0; gi < DEPTH_BYTES; gi++) begin : g_rom_byte
            assign mem[gi] = default_byte(gi);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Byte lanes: lane gi reads byte address+gi. Each lane range-checks its
    // own full-width address, so a word straddling the end of memory mixes
    // real bytes with zeros, and any lane past the end reads 0x00.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [32:0]      lane_addr;
            logic             lane_in_range;
            logic [IDX_W-1:0] lane_idx;
            logic [7:0]       lane_byte;

            assign lane_addr     = {1'b0, address} + 33'(gi);
            assign lane_in_range = (lane_addr < DEPTH_EXT);
            assign lane_idx      = lane_addr[IDX_W-1:0];

            // Out-of-range lanes never index the array.
            always_comb begin
                lane_byte = 8'h00;
                if (lane_in_range) begin
                    lane_byte = mem[lane_idx];
                end
            end

            assign fetch_word[gi*8 +: 8] = lane_byte;
        end
    endgenerate

    // Output register: NOP while reset is high, otherwise the word fetched at this edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            read_instr <= RESET_INSTR;
        end else begin
            read_instr <= fetch_word;
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory with the built-in program.
// Directed vector table, hand-written reset sequences, and random addresses
// checked against a byte-array reference model.
module tb_instruction_memory;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clock;
    logic        reset;
    logic [31:0] address;
    logic [31:0] read_instr;

    int checks;
    int errors;

    // Reference model: plain byte array holding the program.
    logic [7:0] model_mem [0:DEPTH-1];

    instruction_memory #(
        .DEPTH_BYTES(DEPTH),
        .INIT_FILE  (""),
        .RESET_INSTR(NOP)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .address   (address),
        .read_instr(read_instr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] expected;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h", name, actual, expected);
        end else begin
            $display("ok   %s got=%08h", name, actual);
        end
    endtask

    // Model fetch: four bytes from a upward, zero beyond the end, no wrap.
    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] w;
        longint      idx;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            idx = longint'(a) + k;
            if (idx < DEPTH) begin
                w[k*8 +: 8] = model_mem[int'(idx)];
            end
        end
        return w;
    endfunction

    // Present an address between edges; return just after the capturing edge.
    task automatic apply(input logic [31:0] a);
        @(negedge clock);
        address = a;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] prog [5];
        logic [31:0] a;

        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        address = 32'h0;

        prog[0] = 32'h0050_0093;
        prog[1] = 32'h00A0_0113;
        prog[2] = 32'h0020_81B3;
        prog[3] = 32'h0030_2023;
        prog[4] = 32'h0000_2203;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        for (int i = 0; i < 5; i++)
            for (int b = 0; b < 4; b++)
                model_mem[i*4 + b] = prog[i][b*8 +: 8];

        vecs.push_back('{"aligned_0",    32'd0,        32'h0050_0093});
        vecs.push_back('{"aligned_4",    32'd4,        32'h00A0_0113});
        vecs.push_back('{"aligned_16",   32'd16,       32'h0000_2203});
        vecs.push_back('{"unaligned_17", 32'd17,       32'h0000_0022});
        vecs.push_back('{"unaligned_2",  32'd2,        32'h0113_0050});
        vecs.push_back('{"unaligned_14", 32'd14,       32'h2203_0030});
        vecs.push_back('{"b2b_0",        32'd0,        32'h0050_0093});
        vecs.push_back('{"b2b_4",        32'd4,        32'h00A0_0113});
        vecs.push_back('{"b2b_8",        32'd8,        32'h0020_81B3});
        vecs.push_back('{"b2b_12",       32'd12,       32'h0030_2023});
        vecs.push_back('{"blank_20",     32'd20,       32'h0000_0000});
        vecs.push_back('{"oor_1022",     32'd1022,     32'h0000_0000});
        vecs.push_back('{"oor_1024",     32'd1024,     32'h0000_0000});
        vecs.push_back('{"oor_fffffffc", 32'hFFFF_FFFC, 32'h0000_0000});
        vecs.push_back('{"oor_ffffffff", 32'hFFFF_FFFF, 32'h0000_0000});

        // Reset held for two edges keeps the NOP.
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold", read_instr, NOP);

        // First fetch after release.
        @(negedge clock);
        reset   = 1'b0;
        address = 32'd0;
        @(posedge clock);
        #1;
        check("first_fetch", read_instr, 32'h0050_0093);

        // Directed table, applied on consecutive edges.
        foreach (vecs[i]) begin
            apply(vecs[i].addr);
            check(vecs[i].name, read_instr, vecs[i].expected);
        end

        // One-cycle latency: output holds the previous word until the next edge.
        apply(32'd8);
        @(negedge clock);
        address = 32'd12;
        #1;
        check("hold_until_edge", read_instr, 32'h0020_81B3);
        @(posedge clock);
        #1;
        check("after_edge", read_instr, 32'h0030_2023);

        // Asynchronous reset mid-stream, asserted between edges.
        apply(32'd8);
        check("pre_async_reset", read_instr, 32'h0020_81B3);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", read_instr, NOP);
        @(posedge clock);
        #1;
        check("reset_over_edge", read_instr, NOP);
        @(negedge clock);
        reset = 1'b0;
        apply(32'd8);
        check("post_reset_8", read_instr, 32'h0020_81B3);

        // Random addresses against the model: mostly near the program and the
        // end of memory, some across the full 32-bit space.
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = $urandom_range(DEPTH - 8, DEPTH + 8);
                default: a = $urandom_range(0, 31);
            endcase
            apply(a);
            check($sformatf("rand_%0d_a%08h", i, a), read_instr, model_read(a));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
